icache: RTL and testbench

Direct-mapped, one-word-per-line instruction cache between the datapath's instruction fetch port and the memory controller's instruction port. Returns `imemload` with a same-cycle `ihit` on a tag match. On a miss it stalls the fetch (holds `ihit` low), fetches the word from memory, and installs it. Also provides a single-cycle flush and hit/miss performance counters.

---
 rtl/icache_if.sv | 37 +++
 rtl/icache.sv | 113 +++++++++++
 tb/tb_icache.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/icache_if.sv
// rtl/icache_if.sv - fetch-side and memory-side signal bundle for icache
//
// Groups the datapath fetch port, the memory controller instruction port,
// the flush strobe and the performance counters into one interface.
//   slave  : the cache itself (consumes fetch/memory inputs, drives results)
//   master : whoever drives the cache (datapath + memory model)
//
// Signals:
//   imemREN    fetch request            imemaddr   fetch byte address
//   imemload   fetched instruction      ihit       requested word present
//   flush      invalidate all lines     iREN       memory read request
//   iaddr      memory word address      iload      memory read data
//   iwait      memory busy              hit_count  saturating hit cycles
//   miss_count saturating miss count
interface icache_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic [31:0] imemload;
    logic        ihit;
    logic        flush;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    modport slave (
        input  imemREN, imemaddr, flush, iload, iwait,
        output imemload, ihit, iREN, iaddr, hit_count, miss_count
    );

    modport master (
        output imemREN, imemaddr, flush, iload, iwait,
        input  imemload, ihit, iREN, iaddr, hit_count, miss_count
    );
endinterface

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped one-word-per-line instruction cache
//
// Sits between the datapath fetch port and the memory controller. A tag
// match in IDLE returns the word combinationally with ihit; a miss latches
// the word address, moves to FILL, reads memory until iwait drops, installs
// the word and returns to IDLE, where the request hits on the next cycle.
//
// Ports:
//   CLK  : clock, all state on the rising edge
//   RST  : synchronous active-high reset
//   bus  : icache_if.slave (fetch port, memory port, flush, counters)
//
// Parameters:
//   SETS : number of lines, power of two, >= 2
module icache #(
    parameter int SETS = 16
) (
    input  logic     CLK,
    input  logic     RST,
    icache_if.slave  bus
);
    localparam int IDX   = $clog2(SETS);
    localparam int TAG_W = 30 - IDX;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t             r_state;
    logic [SETS-1:0]    r_valid;
    logic [TAG_W-1:0]   r_tag  [SETS];
    logic [31:0]        r_data [SETS];
    logic [31:0]        r_miss_addr;
    logic               r_iren;
    logic [31:0]        r_hit_count;
    logic [31:0]        r_miss_count;

    logic [IDX-1:0]     w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic [IDX-1:0]     w_fill_idx;
    logic [TAG_W-1:0]   w_fill_tag;
    logic               w_hit;
    logic               w_unused_addr_lsbs;

    assign w_idx      = bus.imemaddr[IDX+1:2];
    assign w_tag      = bus.imemaddr[31:IDX+2];
    assign w_fill_idx = r_miss_addr[IDX+1:2];
    assign w_fill_tag = r_miss_addr[31:IDX+2];

    // Byte offset within the word is irrelevant to a word-wide cache.
    assign w_unused_addr_lsbs = &{1'b0, bus.imemaddr[1:0]};

    // Hit only in IDLE: while filling, the fetch is stalled regardless of
    // what the datapath is presenting.
    assign w_hit = (r_state == IDLE) && bus.imemREN && r_valid[w_idx]
                   && (r_tag[w_idx] == w_tag);

    assign bus.ihit       = w_hit;
    assign bus.imemload   = w_hit ? r_data[w_idx] : 32'd0;
    assign bus.iREN       = r_iren;
    // r_miss_addr keeps its last value after a fill, so gate it for IDLE.
    assign bus.iaddr      = r_iren ? r_miss_addr : 32'd0;
    assign bus.hit_count  = r_hit_count;
    assign bus.miss_count = r_miss_count;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= IDLE;
            r_valid      <= '0;
            r_miss_addr  <= 32'd0;
            r_iren       <= 1'b0;
            r_hit_count  <= 32'd0;
            r_miss_count <= 32'd0;
        end else begin
            if (w_hit && (r_hit_count != 32'hFFFF_FFFF)) begin
                r_hit_count <= r_hit_count + 32'd1;
            end

            case (r_state)
                IDLE: begin
                    if (bus.imemREN && !w_hit) begin
                        r_miss_addr <= {bus.imemaddr[31:2], 2'b00};
                        r_iren      <= 1'b1;
                        r_state     <= FILL;
                        if (r_miss_count != 32'hFFFF_FFFF) begin
                            r_miss_count <= r_miss_count + 32'd1;
                        end
                    end
                end
                FILL: begin
                    if (!bus.iwait) begin
                        r_data[w_fill_idx]  <= bus.iload;
                        r_tag[w_fill_idx]   <= w_fill_tag;
                        r_valid[w_fill_idx] <= 1'b1;
                        r_iren              <= 1'b0;
                        r_state             <= IDLE;
                    end
                end
                default: begin
                    r_iren  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase

            // Placed after the fill so a coincident flush leaves the newly
            // filled line invalid; tags and data are kept.
            if (bus.flush) begin
                r_valid <= '0;
            end
        end
    end
endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - directed self-checking bench for icache
module tb_icache;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    icache_if bus ();

    icache #(.SETS(16)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Miss cycle on addr, then waits+1 FILL cycles, the last with iwait=0.
    // Returns just before the cycle in which the line is usable.
    task automatic do_fill(input logic [31:0] a, input logic [31:0] d, input int waits);
        @(negedge clk);
        bus.imemREN  = 1'b1;
        bus.imemaddr = a;
        bus.iload    = d;
        bus.iwait    = 1'b1;
        #1;
        chk("miss_ihit", {31'd0, bus.ihit}, 32'd0);
        chk("miss_iren", {31'd0, bus.iREN}, 32'd0);
        for (int k = 0; k <= waits; k++) begin
            @(negedge clk);
            bus.iwait = (k == waits) ? 1'b0 : 1'b1;
            #1;
            chk("fill_iren", {31'd0, bus.iREN}, 32'd1);
            chk("fill_iaddr", bus.iaddr, {a[31:2], 2'b00});
            chk("fill_ihit", {31'd0, bus.ihit}, 32'd0);
            chk("fill_imemload", bus.imemload, 32'd0);
        end
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b1;
        bus.imemREN  = 1'b0;
        bus.imemaddr = 32'd0;
        bus.flush    = 1'b0;
        bus.iload    = 32'd0;
        bus.iwait    = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_ihit", {31'd0, bus.ihit}, 32'd0);
        chk("rst_imemload", bus.imemload, 32'd0);
        chk("rst_iren", {31'd0, bus.iREN}, 32'd0);
        chk("rst_iaddr", bus.iaddr, 32'd0);
        chk("rst_hit_count", bus.hit_count, 32'd0);
        chk("rst_miss_count", bus.miss_count, 32'd0);
        rst = 1'b0;

        // Cold miss on 0x4, iwait high 3 FILL cycles then low
        do_fill(32'h0000_0004, 32'h8C01_0000, 3);
        @(negedge clk);
        bus.iwait = 1'b1;
        #1;
        chk("cold_ihit", {31'd0, bus.ihit}, 32'd1);
        chk("cold_imemload", bus.imemload, 32'h8C01_0000);
        chk("cold_miss_count", bus.miss_count, 32'd1);
        chk("cold_hit_count", bus.hit_count, 32'd0);

        // Four further hits make five hit cycles in total
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            chk("rehit_ihit", {31'd0, bus.ihit}, 32'd1);
            chk("rehit_iren", {31'd0, bus.iREN}, 32'd0);
        end
        @(negedge clk);
        bus.imemREN = 1'b0;
        #1;
        chk("rehit_hit_count", bus.hit_count, 32'd5);
        chk("idle_no_req_ihit", {31'd0, bus.ihit}, 32'd0);

        // Conflict eviction on index 0
        do_fill(32'h0000_0000, 32'hAAAA_0000, 0);
        do_fill(32'h0000_0040, 32'hBBBB_0000, 0);
        @(negedge clk);
        bus.imemaddr = 32'h0000_0040;
        #1;
        chk("conf_hit40", bus.imemload, 32'hBBBB_0000);
        @(negedge clk);
        bus.imemaddr = 32'h0000_0000;
        bus.iload    = 32'hAAAA_0000;
        bus.iwait    = 1'b1;
        #1;
        chk("conf_miss_ihit", {31'd0, bus.ihit}, 32'd0);
        chk("conf_miss_count", bus.miss_count, 32'd3);
        @(negedge clk);
        bus.iwait = 1'b0;
        #1;
        chk("conf_iren", {31'd0, bus.iREN}, 32'd1);
        chk("conf_iaddr", bus.iaddr, 32'd0);
        chk("conf_miss_count4", bus.miss_count, 32'd4);
        @(negedge clk);
        bus.iwait = 1'b1;
        #1;
        chk("conf_refill_data", bus.imemload, 32'hAAAA_0000);

        // Flush with 0x4 and 0x8 cached
        do_fill(32'h0000_0008, 32'h1234_5678, 1);
        @(negedge clk);
        bus.imemaddr = 32'h0000_0004;
        bus.flush    = 1'b1;
        #1;
        chk("flush_prevalid_ihit", {31'd0, bus.ihit}, 32'd1);
        chk("flush_prevalid_data", bus.imemload, 32'h8C01_0000);
        @(negedge clk);
        bus.flush = 1'b0;
        bus.iload = 32'h8C01_0000;
        #1;
        chk("post_flush_ihit", {31'd0, bus.ihit}, 32'd0);
        chk("post_flush_miss_count", bus.miss_count, 32'd5);
        // Fill completion coinciding with flush
        @(negedge clk);
        bus.iwait = 1'b0;
        bus.flush = 1'b1;
        #1;
        chk("ff_iren", {31'd0, bus.iREN}, 32'd1);
        @(negedge clk);
        bus.flush = 1'b0;
        bus.iwait = 1'b1;
        #1;
        chk("ff_line_invalid_ihit", {31'd0, bus.ihit}, 32'd0);
        chk("ff_idle_iren", {31'd0, bus.iREN}, 32'd0);
        chk("ff_miss_count", bus.miss_count, 32'd6);

        // Reset mid-FILL on 0x10
        bus.imemREN = 1'b0;
        @(negedge clk);
        bus.iwait = 1'b0;
        @(negedge clk);
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h0000_0010;
        bus.iload    = 32'hCAFE_0010;
        bus.iwait    = 1'b1;
        #1;
        chk("rm_miss_ihit", {31'd0, bus.ihit}, 32'd0);
        @(negedge clk);
        #1;
        chk("rm_fill1_iren", {31'd0, bus.iREN}, 32'd1);
        chk("rm_fill1_iaddr", bus.iaddr, 32'h0000_0010);
        @(negedge clk);
        bus.iwait = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rm_iren", {31'd0, bus.iREN}, 32'd0);
        chk("rm_miss_count", bus.miss_count, 32'd0);
        chk("rm_hit_count", bus.hit_count, 32'd0);
        chk("rm_rerequest_ihit", {31'd0, bus.ihit}, 32'd0);
        @(negedge clk);
        #1;
        chk("rm_refill_iren", {31'd0, bus.iREN}, 32'd1);
        chk("rm_refill_miss_count", bus.miss_count, 32'd1);

        // Saturation of hit_count
        @(negedge clk);
        #1;
        chk("sat_first_hit", {31'd0, bus.ihit}, 32'd1);
        chk("sat_data", bus.imemload, 32'hCAFE_0010);
        force dut.r_hit_count = 32'hFFFF_FFFD;
        #1;
        release dut.r_hit_count;
        @(negedge clk);
        #1;
        chk("sat_step", bus.hit_count, 32'hFFFF_FFFE);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("sat_hold", bus.hit_count, 32'hFFFF_FFFF);
        bus.imemREN = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
